ntt_addr_seq: RTL
=================

NTT_ADDR_SEQ -- requirements
Module: ntt_addr_seq

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 4: butterfly pipeline depth in cycles after ROM data is valid.
REQ-002 The block SHALL have parameter STAGE_GAP, default 4: idle cycles inserted between consecutive 32-entry stages (range 1-15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request one full 128-entry pass.
REQ-006 The block SHALL have port stall, input, 1 bit: back-pressure; freezes issue while high.
REQ-007 The block SHALL have port rom_addr, output, 7 bits: address to the butterfly address ROM.
REQ-008 The block SHALL have port rom_rd, output, 1 bit: rom_addr is a valid issue this cycle.
REQ-009 The block SHALL have port wr_ena, output, 1 bit: write enable aligned with the butterfly result.
REQ-010 The block SHALL have port stage, output, 2 bits: stage of the current rom_addr, equal to rom_addr[6:5].
REQ-011 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, GAP, DRAIN and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 SHALL move the FSM to RUN next cycle, with rom_addr=0 and busy=1.
REQ-015 In RUN with stall=0, rom_rd SHALL be 1 for the current rom_addr, and rom_addr SHALL increment by 1 the next cycle.
REQ-016 In RUN with stall=1, rom_rd SHALL be 0 and rom_addr SHALL hold; the delay line keeps shifting.
REQ-017 After issuing an address with addr[4:0]=31 and addr!=127, the FSM SHALL enter GAP for exactly STAGE_GAP cycles (rom_rd=0), then return to RUN at addr+1.
REQ-018 stall SHALL be ignored in GAP and DRAIN; the GAP counter SHALL not be extended by stall.
REQ-019 After issuing address 127, the FSM SHALL enter DRAIN; rom_addr SHALL hold 127, with no wrap to 0.
REQ-020 DRAIN SHALL last PIPE_LAT+1 cycles, until the delay line is empty, then the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0; the FSM SHALL then return to IDLE with rom_addr reset to 0.
REQ-022 wr_ena SHALL equal rom_rd delayed by exactly 1+PIPE_LAT cycles (1 cycle ROM read latency plus pipeline), via a shift register.
REQ-023 start SHALL be ignored in every state except IDLE; start held high in IDLE after DONE SHALL begin a new pass.
REQ-024 Total duration with no stalls SHALL be 128 issue cycles + 3*STAGE_GAP + (PIPE_LAT+1) drain cycles + 1 DONE cycle.
REQ-025 Exactly 128 rom_rd pulses and 128 wr_ena pulses SHALL occur per pass, regardless of stall pattern.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, rom_addr=0, rom_rd=0, wr_ena=0, stage=0, busy=0, done=0, and clear the delay line and gap counter.
REQ-027 Reset asserted mid-pass SHALL abort the pass; no further wr_ena SHALL appear after release until a new start.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-029 Defaults, one start pulse, stall=0 -> rom_rd pulses on addresses 0..127 in order; gaps of 4 cycles after addresses 31, 63 and 95; done is 1 exactly 128+12+5+1=146 cycles after busy rises; 128 wr_ena pulses.
REQ-030 rom_rd at address 5 -> wr_ena high exactly 5 cycles later.
REQ-031 stall=1 for 3 cycles at address 40 -> rom_addr holds 40 with rom_rd=0 for those cycles; sequence resumes at 40; done is delayed by exactly 3 cycles.
REQ-032 start pulsed during RUN and again during DRAIN -> no effect; single pass, single done.
REQ-033 rst_n low for 1 cycle at address 70 -> all outputs 0 immediately; no wr_ena afterward; a new start restarts issue from address 0.
REQ-034 PIPE_LAT=0, STAGE_GAP=1 -> wr_ena lags rom_rd by 1 cycle; gaps are 1 cycle; done 128+3+1+1 cycles after start.

Source files
------------

// File: rtl/ntt_addr_seq.sv
// NTT butterfly address sequencer.
// Issues ROM addresses 0..127 as four 32-entry stages separated by idle gaps.
// It then drains the butterfly pipeline and pulses done.
// wr_ena is rom_rd delayed by the ROM read cycle plus the butterfly pipeline depth.
module ntt_addr_seq #(
    parameter int PIPE_LAT  = 4,
    parameter int STAGE_GAP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic [6:0] rom_addr,
    output logic       rom_rd,
    output logic       wr_ena,
    output logic [1:0] stage,
    output logic       busy,
    output logic       done
);

    // Delay from issue to write-back: one ROM read cycle plus the pipeline.
    localparam int DLY     = PIPE_LAT + 1;
    // One down-counter times both the stage gaps and the drain.
    localparam int CNT_MAX = (PIPE_LAT > STAGE_GAP) ? PIPE_LAT : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DLY-1:0]   dly;
    logic [6:0]       addr_inc;

    assign addr_inc = rom_addr + 7'd1;
    assign wr_ena   = dly[DLY-1];

    // Control FSM. stall is sampled on the edge that opens an issue slot.
    // rom_rd therefore describes the issue decided on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            stage    <= '0;
            rom_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        rom_addr <= '0;
                        stage    <= '0;
                        rom_rd   <= !stall;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (rom_rd) begin
                        if (rom_addr == 7'd127) begin
                            // Last address issued; hold it while the pipeline empties.
                            state  <= DRAIN;
                            rom_rd <= 1'b0;
                            cnt    <= CNT_W'(PIPE_LAT);
                        end else if (rom_addr[4:0] == 5'd31) begin
                            // End of a 32-entry stage; the address advances on exit.
                            state  <= GAP;
                            rom_rd <= 1'b0;
                            cnt    <= CNT_W'(STAGE_GAP - 1);
                        end else begin
                            rom_addr <= addr_inc;
                            stage    <= addr_inc[6:5];
                            rom_rd   <= !stall;
                        end
                    end else begin
                        // Stalled slot: the address holds until the issue goes out.
                        rom_rd <= !stall;
                    end
                end
                GAP: begin
                    // Fixed-length gap; stall neither extends nor shortens it.
                    if (cnt == '0) begin
                        state    <= RUN;
                        rom_addr <= addr_inc;
                        stage    <= addr_inc[6:5];
                        rom_rd   <= !stall;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    rom_addr <= '0;
                    stage    <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-enable delay line. It keeps shifting regardless of stall.
    // Reset empties it, so an aborted pass leaves no pending writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly[0] <= rom_rd;
            for (int i = 1; i < DLY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

endmodule
